// File: rtl/clk_1k_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clk_1k_monitor                                                |
// | Function : Measures period/high time of an async slow clock; lock/loss.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clk_1k_monitor #(
  parameter int NOMINAL_PERIOD = 100000,
  parameter int TOLERANCE      = 1000,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk_100M_i,
  input  logic          rst_i,
  input  logic          clk_1k_i,
  output logic          tick_o,
  output logic [CW-1:0] period_o,
  output logic [CW-1:0] high_o,
  output logic          period_valid_o,
  output logic          locked_o,
  output logic          timeout_o
);

  localparam int            c_GW      = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] c_TIMEOUT = CW'(TIMEOUT_CYCLES);
  localparam logic [c_GW-1:0] c_LOCK  = c_GW'(LOCK_COUNT);
  // Window bounds held at 32 bits so the low bound cannot wrap below zero.
  localparam logic [31:0] c_LO = (NOMINAL_PERIOD >= TOLERANCE) ?
                                 32'(NOMINAL_PERIOD - TOLERANCE) : 32'd0;
  localparam logic [31:0] c_HI = 32'(NOMINAL_PERIOD + TOLERANCE);

  localparam logic [1:0] c_ST_ACQUIRE = 2'd0;
  localparam logic [1:0] c_ST_TRACK   = 2'd1;
  localparam logic [1:0] c_ST_LOCKED  = 2'd2;
  localparam logic [1:0] c_ST_LOST    = 2'd3;

  logic            r_sync1;
  logic            r_sync2;
  logic            r_hist;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_state;
  logic [c_GW-1:0] r_good_cnt;
  logic [CW-1:0]   r_period;
  logic [CW-1:0]   r_high;
  logic            r_period_valid;
  logic            r_locked;
  logic            r_timeout;

  logic            w_rise;
  logic            w_fall;
  logic            w_timeout_hit;
  logic            w_good;
  logic [31:0]     w_cnt_ext;
  logic [c_GW-1:0] w_good_inc;
  logic [1:0]      w_state_next;
  logic [c_GW-1:0] w_good_next;
  logic            w_report;
  logic            w_high_load;
  logic            w_locked_next;
  logic            w_timeout_next;

  always_ff @(posedge clk_100M_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= clk_1k_i;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_hist;
  assign w_fall = ~r_sync2 & r_hist;

  always_ff @(posedge clk_100M_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CW'(1);
    end else if (r_cnt != c_TIMEOUT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A saturated count means the true period is unknown, so it is never good.
  assign w_cnt_ext     = 32'(r_cnt);
  assign w_good        = (w_cnt_ext >= c_LO) && (w_cnt_ext <= c_HI) && (r_cnt != c_TIMEOUT);
  assign w_good_inc    = (r_good_cnt == c_LOCK) ? r_good_cnt : r_good_cnt + 1'b1;
  assign w_timeout_hit = (r_cnt == c_TIMEOUT) && !w_rise;

  // State register and registered outputs
  always_ff @(posedge clk_100M_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= c_ST_ACQUIRE;
      r_good_cnt     <= '0;
      r_period       <= '0;
      r_high         <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_good_cnt     <= w_good_next;
      r_period_valid <= w_report;
      r_locked       <= w_locked_next;
      r_timeout      <= w_timeout_next;
      if (w_report) begin
        r_period <= r_cnt;
      end
      if (w_high_load) begin
        r_high <= r_cnt;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    w_report     = 1'b0;
    w_high_load  = 1'b0;
    case (r_state)
      c_ST_ACQUIRE: begin
        if (w_rise) begin
          w_state_next = c_ST_TRACK;
        end else if (w_timeout_hit) begin
          w_state_next = c_ST_LOST;
          w_good_next  = '0;
        end
      end
      c_ST_TRACK, c_ST_LOCKED: begin
        w_high_load = w_fall;
        if (w_rise) begin
          w_report = 1'b1;
          if (w_good) begin
            w_good_next = w_good_inc;
            if (w_good_inc == c_LOCK) begin
              w_state_next = c_ST_LOCKED;
            end
          end else begin
            w_good_next  = '0;
            w_state_next = c_ST_TRACK;
          end
        end else if (w_timeout_hit) begin
          w_state_next = c_ST_LOST;
          w_good_next  = '0;
        end
      end
      c_ST_LOST: begin
        w_high_load = w_fall;
        if (w_rise) begin
          w_state_next = c_ST_TRACK;
        end
      end
      default: begin
        w_state_next = c_ST_ACQUIRE;
        w_good_next  = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_locked_next  = (w_state_next == c_ST_LOCKED);
    w_timeout_next = (w_state_next == c_ST_LOST);
  end

  assign tick_o         = w_rise;
  assign period_o       = r_period;
  assign high_o         = r_high;
  assign period_valid_o = r_period_valid;
  assign locked_o       = r_locked;
  assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_clk_1k_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clk_1k_monitor                                             |
// | Function : Self-checking bench for clk_1k_monitor.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_clk_1k_monitor;

  localparam int NOM  = 100;
  localparam int TOL  = 2;
  localparam int LOCK = 4;
  localparam int TO   = 200;
  localparam int CW   = $clog2(TO + 1);

  logic          clk_100M = 1'b0;
  logic          rst      = 1'b1;
  logic          clk_1k   = 1'b0;
  logic          tick;
  logic [CW-1:0] period;
  logic [CW-1:0] high;
  logic          pv;
  logic          locked;
  logic          timeout;

  clk_1k_monitor #(
    .NOMINAL_PERIOD (NOM),
    .TOLERANCE      (TOL),
    .LOCK_COUNT     (LOCK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_100M_i     (clk_100M),
    .rst_i          (rst),
    .clk_1k_i       (clk_1k),
    .tick_o         (tick),
    .period_o       (period),
    .high_o         (high),
    .period_valid_o (pv),
    .locked_o       (locked),
    .timeout_o      (timeout)
  );

  always #5 clk_100M = ~clk_100M;

  int n_checks = 0;
  int n_errors = 0;
  int tick_seen = 0;
  int pv_seen = 0;

  // Reference model: events are timestamps in fast-clock cycles since reset release.
  int w;
  int ref_w;
  bit lvl_q[$];
  bit m_have_ref;
  bit m_lost;
  int m_streak;
  int m_period;
  int m_high;
  bit m_pv;

  typedef struct {
    int period;
    int reps;
    bit exp_locked;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    w          = 0;
    ref_w      = 0;
    m_have_ref = 1'b0;
    m_lost     = 1'b0;
    m_streak   = 0;
    m_period   = 0;
    m_high     = 0;
    m_pv       = 1'b0;
    lvl_q.delete();
    lvl_q.push_back(clk_1k);
  endtask

  // One fast-clock cycle: observe, compare, advance the model, then drive lvl.
  task automatic step(input bit lvl);
    bit a;
    bit b;
    bit rise_w;
    bit fall_w;
    int cnt_w;
    @(posedge clk_100M);
    #1;
    w++;
    a      = (w >= 2) ? lvl_q[w-2] : 1'b0;
    b      = (w >= 3) ? lvl_q[w-3] : 1'b0;
    rise_w = a && !b;
    fall_w = !a && b;
    cnt_w  = ((w - ref_w) > TO) ? TO : (w - ref_w);

    chk("tick", 32'(tick), 32'(rise_w));
    chk("period_valid", 32'(pv), 32'(m_pv));
    chk("period", 32'(period), m_period);
    chk("high", 32'(high), m_high);
    chk("locked", 32'(locked), 32'(m_have_ref && !m_lost && m_streak >= LOCK));
    chk("timeout", 32'(timeout), 32'(m_lost));
    if (tick) tick_seen++;
    if (pv) pv_seen++;

    m_pv = 1'b0;
    if (fall_w && (m_have_ref || m_lost)) m_high = cnt_w;
    if (rise_w) begin
      if (m_have_ref) begin
        m_period = cnt_w;
        m_pv     = 1'b1;
        if (cnt_w < TO && cnt_w >= NOM - TOL && cnt_w <= NOM + TOL)
          m_streak = (m_streak + 1 > LOCK) ? LOCK : m_streak + 1;
        else
          m_streak = 0;
      end
      m_have_ref = 1'b1;
      m_lost     = 1'b0;
      ref_w      = w;
    end else if (cnt_w == TO && !m_lost) begin
      m_lost     = 1'b1;
      m_have_ref = 1'b0;
      m_streak   = 0;
    end

    clk_1k = lvl;
    lvl_q.push_back(lvl);
  endtask

  // Low first, then high; the rise therefore closes a period of length p.
  task automatic period_lh(input int p, input int h);
    repeat (p - h) step(1'b0);
    repeat (h) step(1'b1);
  endtask

  task automatic release_reset();
    @(posedge clk_100M);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_pv"}, 32'(pv), 32'd0);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_high"}, 32'(high), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int p;
    int h;
    int pv0;
    int t0;

    vecs[0] = '{100, 5, 1'b1, 100, 50};
    vecs[1] = '{103, 1, 1'b0, 103, 50};
    vecs[2] = '{100, 3, 1'b0, 100, 50};
    vecs[3] = '{100, 1, 1'b1, 100, 50};
    vecs[4] = '{ 97, 1, 1'b0,  97, 50};
    vecs[5] = '{ 98, 2, 1'b0,  98, 50};
    vecs[6] = '{102, 2, 1'b1, 102, 50};
    vecs[7] = '{101, 1, 1'b1, 101, 50};
    vecs[8] = '{ 99, 1, 1'b1,  99, 50};

    repeat (2) @(posedge clk_100M);
    #1;
    check_all_zero("reset");
    release_reset();

    for (int i = 0; i < 9; i++) begin
      repeat (vecs[i].reps) period_lh(vecs[i].period, 50);
      chk($sformatf("vec%0d_period", i), 32'(period), vecs[i].exp_period);
      chk($sformatf("vec%0d_high", i), 32'(high), vecs[i].exp_high);
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
    end

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(7, 0) == 0) p = int'($urandom_range(219, 180));
      else                           p = int'($urandom_range(106, 94));
      h = int'($urandom_range(p - 1, 1));
      period_lh(p, h);
    end

    // Loss: hold low well past the timeout, then recover in two rises.
    period_lh(100, 50);
    repeat (210) step(1'b0);
    chk("lost_timeout", 32'(timeout), 32'd1);
    chk("lost_locked", 32'(locked), 32'd0);
    pv0 = pv_seen;
    repeat (50) step(1'b1);
    chk("recover_timeout", 32'(timeout), 32'd0);
    chk("recover_no_report", 32'(pv_seen - pv0), 32'd0);
    period_lh(100, 50);
    chk("recover_report", 32'(pv_seen - pv0), 32'd1);
    chk("recover_period", 32'(period), 32'd100);

    // Mid-period reset while locked.
    repeat (4) period_lh(100, 50);
    chk("prereset_locked", 32'(locked), 32'd1);
    repeat (20) step(1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk_100M);
    release_reset();
    pv0 = pv_seen;
    period_lh(100, 50);
    chk("post_reset_first_rise", 32'(pv_seen - pv0), 32'd0);
    period_lh(100, 50);
    chk("post_reset_second_rise", 32'(pv_seen - pv0), 32'd1);
    chk("post_reset_period", 32'(period), 32'd100);

    // Input already high at reset release counts as the first rise.
    @(posedge clk_100M);
    #2;
    rst    = 1'b1;
    clk_1k = 1'b1;
    repeat (2) @(posedge clk_100M);
    release_reset();
    t0  = tick_seen;
    pv0 = pv_seen;
    repeat (49) step(1'b1);
    chk("high_release_tick", 32'(tick_seen - t0), 32'd1);
    chk("high_release_no_report", 32'(pv_seen - pv0), 32'd0);
    repeat (50) step(1'b0);
    repeat (10) step(1'b1);
    chk("high_release_period", 32'(period), 32'd100);
    chk("high_release_report", 32'(pv_seen - pv0), 32'd1);

    // Rise landing exactly on the timeout count: rise wins, period is bad.
    pv0 = pv_seen;
    repeat (40) step(1'b1);
    repeat (150) step(1'b0);
    repeat (10) step(1'b1);
    chk("tie_period", 32'(period), 32'd200);
    chk("tie_timeout", 32'(timeout), 32'd0);
    chk("tie_locked", 32'(locked), 32'd0);
    chk("tie_report", 32'(pv_seen - pv0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_1k_monitor.md
CLK_1K_MONITOR -- requirements
Module: clk_1k_monitor

Interface
REQ-001 SHALL have parameter NOMINAL_PERIOD, default 100000, expected input period in clk_100M_i cycles.
REQ-002 SHALL have parameter TOLERANCE, default 1000, maximum allowed |period - NOMINAL_PERIOD| in cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, number of consecutive good periods required to lock.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 200000, number of cycles without a rising edge that declares loss; CW = $clog2(TIMEOUT_CYCLES+1).
REQ-005 SHALL use one clock, clk_100M_i; reset rst_i is asynchronous and active-high.
REQ-006 clk_100M_i  input  1  system clock, all state on its rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 clk_1k_i  input  1  asynchronous slow clock under measurement.
REQ-009 tick_o  output  1  one-cycle pulse per synchronized rising edge of clk_1k_i.
REQ-010 period_o  output  CW  last measured rising-to-rising period, in cycles.
REQ-011 high_o  output  CW  last measured rising-to-falling high time, in cycles.
REQ-012 period_valid_o  output  1  one-cycle pulse when period_o updates.
REQ-013 locked_o  output  1  input frequency within tolerance for LOCK_COUNT consecutive periods.
REQ-014 timeout_o  output  1  no rising edge seen for TIMEOUT_CYCLES cycles.

Function
REQ-015 clk_1k_i SHALL pass through a 2-flop synchronizer followed by a history flop; rise = sync2 & ~hist; fall = ~sync2 & hist.
REQ-016 tick_o SHALL equal rise: high exactly one cycle, during the cycle after the 2nd clk_100M_i edge that samples clk_1k_i high.
REQ-017 Counter cnt (CW bits) SHALL load 1 on a rise cycle, otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-018 Consequently, at a rise, cnt SHALL equal the cycles since the previous rise; at a fall, it SHALL equal the cycles since the previous rise.
REQ-019 FSM states SHALL be ACQUIRE (reset state), TRACK, LOCKED, and LOST.
REQ-020 ACQUIRE: on rise, go to TRACK without reporting a period (no prior edge).
REQ-021 TRACK/LOCKED: on rise, register period_o <= cnt, pulse period_valid_o the next cycle, and classify the period.
REQ-022 A period SHALL be good iff NOMINAL_PERIOD-TOLERANCE <= period <= NOMINAL_PERIOD+TOLERANCE; comparisons SHALL be unsigned and evaluated without underflow.
REQ-023 A good period SHALL increment good_cnt (saturating at LOCK_COUNT); when good_cnt reaches LOCK_COUNT, go to LOCKED.
REQ-024 A bad period SHALL clear good_cnt to 0 and go to (or stay in) TRACK.
REQ-025 In TRACK/LOCKED/LOST, on fall, register high_o <= cnt; high_o SHALL NOT update in ACQUIRE.
REQ-026 In any state except LOST, if cnt == TIMEOUT_CYCLES and there is no rise, go to LOST and clear good_cnt.
REQ-027 LOST: on rise, go to TRACK, with no period report and cnt reloaded to 1.
REQ-028 If a rise and the timeout occur in the same cycle, the rise SHALL win; period = TIMEOUT_CYCLES, classified bad.
REQ-029 locked_o SHALL be 1 iff state is LOCKED, and timeout_o SHALL be 1 iff state is LOST; both registered, updating the cycle after the causing event.

Reset
REQ-030 rst_i high SHALL immediately clear the sync/history flops, cnt, good_cnt, period_o, high_o, and all 1-bit outputs to 0, and force ACQUIRE.
REQ-031 Reset asserted mid-measurement SHALL discard the partial period; the first rise after release SHALL NOT produce period_valid_o.
REQ-032 If clk_1k_i is high at reset release, one tick_o SHALL occur (history flop resets to 0) and be treated as the first rise.

Verification
REQ-033 Benches SHALL use NOMINAL_PERIOD=100, TOLERANCE=2, LOCK_COUNT=4, TIMEOUT_CYCLES=200.
REQ-034 Square wave, period 100 with 50 high -> 1st rise: tick only; each later rise: period_o=100, high_o=50, period_valid_o 1-cycle pulse; locked_o=1 after the 5th rise.
REQ-035 Locked, then one period of 103 -> locked_o=0 the cycle after that period_valid_o; returning to 100-cycle periods relocks after 4 further good periods.
REQ-036 Periods 98 and 102 -> classified good (locking proceeds); period 97 -> bad, good_cnt cleared.
REQ-037 Input held low after a rise -> timeout_o=1 and locked_o=0 at cnt=200; next rise -> timeout_o=0, no period_valid_o; following rise -> valid period report.
REQ-038 rst_i pulsed mid-period while LOCKED -> all outputs 0 asynchronously; after release, the 1st rise gives no period report and the 2nd rise reports period_o=100.
